axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
AXI4-Lite memory slave that sits directly downstream of the IFU/LSU bus arbiter and terminates its single shared master port. It serves one outstanding read and one outstanding write from an internal word-addressed SRAM array, with a programmable response latency. Out-of-range accesses complete with an error response.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, address bus width.
BASE_ADDR, 32'h8000_0000, byte address of word 0.
DEPTH, 4096, number of 32-bit words in the array.
FIXED_LAT, 2, extra cycles between request capture and response valid (0..15).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset; synchronous, active-high.
araddr  in  ADDR_WIDTH  read address.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
rdata  out  DATA_WIDTH  read data.
rresp  out  1  0=OKAY, 1=error.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
awaddr  in  ADDR_WIDTH  write address.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
wdata  in  DATA_WIDTH  write data.
wstrb  in  8  byte strobes; bits[3:0] map to bytes 3..0; bits[7:4] are ignored.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
bresp  out  1  0=OKAY, 1=error.
bvalid  out  1  write response valid.
bready  in  1  write response ready.

Behaviour:
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. All outputs are registered.
- Reset applied mid-transaction aborts it: both FSMs return to IDLE, valids drop, and pending writes are discarded. The array is never cleared.
- Address decode: index = (addr-BASE_ADDR)>>2. The address is in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH. The low two address bits are ignored.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On arvalid&arready (cycle T), latch the address, load the counter with the latency, and drop arready. If latency=0, go to R_RESP; otherwise go to R_WAIT.
  - R_WAIT: decrement the counter each cycle. On reaching 1, go to R_RESP.
  - On entry to R_RESP: read the array, drive rdata/rresp, and set rvalid. For FIXED_LAT=L, rvalid first rises at cycle T+1+L.
  - R_RESP: hold rdata, rresp and rvalid stable until rvalid&rready. In that cycle clear rvalid, return to R_IDLE, and raise arready the next cycle.
  - Out-of-range read: rdata=0, rresp=1.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: AW and W handshake independently and in either order. Each ready drops after its own handshake; same-cycle handshakes are allowed.
  - When both AW and W are captured, load the counter, then follow the same countdown as the read FSM.
  - On entry to W_RESP: commit the write (per-byte enable from wstrb[3:0]) and set bvalid.
  - W_RESP: hold bresp and bvalid until bready. Then return to W_IDLE and reassert awready/wready next cycle.
  - Out-of-range write: no array update, bresp=1.
  - wstrb[3:0]=0: no bytes change, bresp=0.
- The read and write FSMs are fully independent. If a read samples a word in the same cycle a write commits to it, the read returns the old data.
- With no rready or bready, the slave stalls indefinitely; there is no timeout.

Optional Feature:
RAND_DELAY_EN.
- Defined: the latency of each request comes from an 8-bit Galois LFSR (polynomial x^8+x^6+x^5+x^4+1, seed 8'h5A on reset), using bits[3:0].
  - The LFSR advances once per accepted AR or AW handshake; when both occur in the same cycle, the AR handshake consumes the value first.
  - FIXED_LAT is ignored.
- Undefined: latency = FIXED_LAT for every request.

Decomposition:
- Shared define file para.v holds:
  - R_IDLE/R_WAIT/R_RESP and W_IDLE/W_WAIT/W_RESP encodings (2-bit, with the team suffix);
  - response codes AXI_RESP_OKAY=0, AXI_RESP_ERR=1;
  - default BASE_ADDR.
- Sub-module axi_lat_gen provides the latency source: LFSR or constant selected by RAND_DELAY_EN, inputs clk/rst/advance, output lat[3:0].
- The array is inferred in-module with a byte-enable write.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x8000_0010 with wstrb=8'h0F, bready=1 -> bvalid at T+3, bresp=0. Then read 0x8000_0010 -> rvalid at T+3, rdata=32'hDEADBEEF, rresp=0.
- Write 32'h0000_AA00 to 0x8000_0010 with wstrb=8'h02 -> a subsequent read returns 32'hDEADAAEF.
- W handshake 3 cycles before AW (wready low after its handshake, awready still high) -> a single write commits after AW arrives, and exactly one bvalid pulse is produced.
- Read 0x7FFF_FFFC and 0x8000_4000 (DEPTH=4096) -> rresp=1, rdata=0. Write to 0x8000_4000 -> bresp=1 and the array is unchanged.
- Hold rready=0 for 5 cycles after rvalid -> rvalid and rdata stay stable, arready stays 0. Raise rready -> rvalid drops the next cycle and arready returns to 1.
- Assert rst during R_WAIT of a pending read -> next cycle arready=1, rvalid=0. A prior memory write is still readable afterwards.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM slave.
package axi_sram_slave_pkg;

    typedef enum logic [1:0] {
        RIdle = 2'd0,
        RWait = 2'd1,
        RResp = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WIdle = 2'd0,
        WWait = 2'd1,
        WResp = 2'd2
    } wr_state_e;

    localparam logic AXI_RESP_OKAY = 1'b0;
    localparam logic AXI_RESP_ERR  = 1'b1;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/axi_lat_gen.sv
// Per-request response latency source: 8-bit Galois LFSR when RAND_DELAY_EN is defined,
// otherwise the constant FIXED_LAT.
module axi_lat_gen #(
    parameter int unsigned FIXED_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] advance,   // {aw_handshake, ar_handshake}
    output logic [3:0] lat,       // value consumed by the first handshake this cycle
    output logic [3:0] lat_next   // value consumed by AW when AR also fires this cycle
);

`ifdef RAND_DELAY_EN
    // x^8+x^6+x^5+x^4+1, right-shifting Galois form
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    logic [7:0] lfsr_q, lfsr_d, lfsr_1;
    logic [3:0] unused_fixed;

    assign unused_fixed = 4'(FIXED_LAT);
    assign lfsr_1       = lfsr_step(lfsr_q);

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance == 2'b11) begin
            lfsr_d = lfsr_step(lfsr_1);
        end else if (|advance) begin
            lfsr_d = lfsr_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lat      = lfsr_q[3:0];
    assign lat_next = lfsr_1[3:0];
`else
    logic unused_inputs;

    assign unused_inputs = ^{clk, rst, advance};
    assign lat           = 4'(FIXED_LAT);
    assign lat_next      = 4'(FIXED_LAT);
`endif

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-Lite SRAM slave: one outstanding read and one outstanding write with a programmable
// response latency. Define RAND_DELAY_EN to draw each request's latency from an LFSR.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
    parameter int unsigned            DEPTH      = 4096,
    parameter int unsigned            FIXED_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [7:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int unsigned           IdxW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0]   Span = (ADDR_WIDTH + 1)'(4 * DEPTH);

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (off < Span);
    endfunction

    function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = (a - BASE_ADDR) >> 2;
        return IdxW'(off);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    rd_state_e             rd_state_q, rd_state_d;
    logic [3:0]            rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rresp_q, rresp_d;

    wr_state_e             wr_state_q, wr_state_d;
    logic [3:0]            wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [3:0]            aw_lat_q, aw_lat_d;
    logic                  awready_q, awready_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  bresp_q, bresp_d;

    logic                  ar_hs, aw_hs, w_hs;
    logic [3:0]            lat, lat_next, lat_ar, lat_aw, wl;
    logic                  rd_load;
    logic [ADDR_WIDTH-1:0] rd_sel;
    logic                  commit, mem_we;
    logic [ADDR_WIDTH-1:0] cm_addr;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [3:0]            cm_strb;
    logic                  unused_wstrb;

    assign ar_hs        = arvalid & arready_q;
    assign aw_hs        = awvalid & awready_q;
    assign w_hs         = wvalid & wready_q;
    assign unused_wstrb = ^wstrb[7:4];

    axi_lat_gen #(
        .FIXED_LAT (FIXED_LAT)
    ) u_lat_gen (
        .clk      (clk),
        .rst      (rst),
        .advance  ({aw_hs, ar_hs}),
        .lat      (lat),
        .lat_next (lat_next)
    );

    // AR consumes the LFSR value first when both address handshakes coincide.
    assign lat_ar = lat;
    assign lat_aw = ar_hs ? lat_next : lat;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        araddr_d   = araddr_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_load    = 1'b0;
        rd_sel     = araddr_q;
        unique case (rd_state_q)
            RIdle: begin
                if (ar_hs) begin
                    araddr_d  = araddr;
                    arready_d = 1'b0;
                    if (lat_ar == 4'd0) begin
                        rd_load    = 1'b1;
                        rd_sel     = araddr;
                        rd_state_d = RResp;
                    end else begin
                        rd_cnt_d   = lat_ar;
                        rd_state_d = RWait;
                    end
                end
            end
            RWait: begin
                rd_cnt_d = rd_cnt_q - 4'd1;
                if (rd_cnt_q == 4'd1) begin
                    rd_load    = 1'b1;
                    rd_state_d = RResp;
                end
            end
            RResp: begin
                if (rvalid_q && rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RIdle;
                end
            end
            default: rd_state_d = RIdle;
        endcase
        if (rd_load) begin
            rvalid_d = 1'b1;
            if (addr_ok(rd_sel)) begin
                rdata_d = mem[addr_idx(rd_sel)];
                rresp_d = AXI_RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = AXI_RESP_ERR;
            end
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        awaddr_d   = awaddr_q;
        aw_lat_d   = aw_lat_q;
        awready_d  = awready_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wl         = aw_lat_q;
        commit     = 1'b0;
        cm_addr    = awaddr_q;
        cm_data    = wdata_q;
        cm_strb    = wstrb_q;
        unique case (wr_state_q)
            WIdle: begin
                if (aw_hs) begin
                    awaddr_d  = awaddr;
                    aw_lat_d  = lat_aw;
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    wdata_d  = wdata;
                    wstrb_d  = wstrb[3:0];
                    wready_d = 1'b0;
                end
                // A low ready means that channel was already captured in an earlier cycle.
                if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
                    wl = aw_hs ? lat_aw : aw_lat_q;
                    if (wl == 4'd0) begin
                        commit     = 1'b1;
                        cm_addr    = aw_hs ? awaddr : awaddr_q;
                        cm_data    = w_hs ? wdata : wdata_q;
                        cm_strb    = w_hs ? wstrb[3:0] : wstrb_q;
                        wr_state_d = WResp;
                    end else begin
                        wr_cnt_d   = wl;
                        wr_state_d = WWait;
                    end
                end
            end
            WWait: begin
                wr_cnt_d = wr_cnt_q - 4'd1;
                if (wr_cnt_q == 4'd1) begin
                    commit     = 1'b1;
                    wr_state_d = WResp;
                end
            end
            WResp: begin
                if (bvalid_q && bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = WIdle;
                end
            end
            default: wr_state_d = WIdle;
        endcase
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = addr_ok(cm_addr) ? AXI_RESP_OKAY : AXI_RESP_ERR;
        end
    end

    assign mem_we = commit && addr_ok(cm_addr);

    // Not reset: contents survive reset; a same-edge read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_strb[b]) begin
                    mem[addr_idx(cm_addr)][8*b +: 8] <= cm_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RIdle;
            rd_cnt_q   <= '0;
            araddr_q   <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= AXI_RESP_OKAY;
            wr_state_q <= WIdle;
            wr_cnt_q   <= '0;
            awaddr_q   <= '0;
            aw_lat_q   <= '0;
            awready_q  <= 1'b1;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXI_RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            araddr_q   <= araddr_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            awaddr_q   <= awaddr_d;
            aw_lat_q   <= aw_lat_d;
            awready_q  <= awready_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized self-checking bench for axi_sram_slave (default build, fixed latency).
module tb_axi_sram_slave;

    localparam int unsigned LAT   = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 4096;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        bready;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference memory: word index -> contents, only for words the bench has written.
    logic [31:0] mdl [int];

    axi_sram_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .DEPTH      (DEPTH),
        .FIXED_LAT  (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned la, lb;
        la = longint'(a);
        lb = longint'(BASE);
        return (la >= lb) && (la < lb + 64'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] pool(input int i);
        return BASE + 32'(i * 1012);
    endfunction

    function automatic logic [31:0] oor_addr();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0:       a = BASE - 32'd4;
            1:       a = BASE + 32'(4 * DEPTH);
            2:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
            default: a = 32'($urandom_range(0, 32'h7FFF_0000));
        endcase
        return a;
    endfunction

    task automatic do_read(input logic [31:0] addr, input int stall);
        int          cyc;
        int          lat;
        logic [31:0] held;
        araddr  = addr;
        arvalid = 1'b1;
        cyc     = 0;
        while (!arready && cyc < 60) begin
            tick();
            cyc++;
        end
        if (!arready) begin
            check("rd_ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            return;
        end
        tick();
        arvalid = 1'b0;
        check("rd_arready_low", 32'(arready), 32'd0);
        lat = 0;
        while (!rvalid && lat < 60) begin
            tick();
            lat++;
        end
        check("rd_latency", 32'(lat), 32'(LAT));
        check("rd_rresp", 32'(rresp), 32'(!in_rng(addr)));
        if (!in_rng(addr)) check("rd_oor_data", rdata, 32'd0);
        else if (mdl.exists(widx(addr))) check("rd_data", rdata, mdl[widx(addr)]);
        held = rdata;
        repeat (stall) begin
            tick();
            check("rd_hold_valid", 32'(rvalid), 32'd1);
            check("rd_hold_data", rdata, held);
            check("rd_hold_arready", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd_rvalid_drop", 32'(rvalid), 32'd0);
        check("rd_arready_back", 32'(arready), 32'd1);
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: same cycle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] strb, input int lead, input int stall);
        int cyc;
        int lat;
        bit aw_done, w_done, hs_aw, hs_w;
        int aw_start, w_start;
        logic [31:0] old;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        awaddr   = addr;
        wdata    = data;
        wstrb    = strb;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        cyc      = 0;
        while (!(aw_done && w_done) && cyc < 60) begin
            awvalid = !aw_done && (cyc >= aw_start);
            wvalid  = !w_done && (cyc >= w_start);
            hs_aw   = awvalid && awready;
            hs_w    = wvalid && wready;
            tick();
            cyc++;
            if (hs_aw) aw_done = 1'b1;
            if (hs_w) w_done = 1'b1;
            if (w_done && !aw_done) begin
                check("wr_wready_low", 32'(wready), 32'd0);
                check("wr_awready_high", 32'(awready), 32'd1);
                check("wr_no_early_b", 32'(bvalid), 32'd0);
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_hs_timeout", 32'd0, 32'd1);
            return;
        end
        lat = 0;
        while (!bvalid && lat < 60) begin
            tick();
            lat++;
        end
        check("wr_latency", 32'(lat), 32'(LAT));
        check("wr_bresp", 32'(bresp), 32'(!in_rng(addr)));
        repeat (stall) begin
            tick();
            check("wr_hold_bvalid", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr_bvalid_drop", 32'(bvalid), 32'd0);
        check("wr_ready_back", {30'd0, awready, wready}, 32'd3);
        tick();
        check("wr_single_pulse", 32'(bvalid), 32'd0);
        if (in_rng(addr)) begin
            old = mdl.exists(widx(addr)) ? mdl[widx(addr)] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) old[8*b +: 8] = data[8*b +: 8];
            end
            mdl[widx(addr)] = old;
        end
    endtask

    initial begin
        rst     = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        repeat (3) tick();
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resps", {30'd0, rresp, bresp}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed scenarios.
        do_write(BASE + 32'h10, 32'hDEAD_BEEF, 8'h0F, 0, 0);
        do_read(BASE + 32'h10, 0);
        do_write(BASE + 32'h10, 32'h0000_AA00, 8'h02, 0, 0);
        do_read(BASE + 32'h10, 0);
        check("merge_value", rdata, 32'hDEAD_AAEF);
        do_write(BASE + 32'h20, 32'h1234_5678, 8'hFF, 3, 0);
        do_read(BASE + 32'h20, 0);
        do_write(BASE + 32'h24, 32'hCAFE_F00D, 8'hF0, 0, 1);

        for (int i = 0; i < 16; i++) do_write(pool(i), $urandom, 8'h0F, 0, 0);

        do_read(32'h7FFF_FFFC, 0);
        do_read(32'h8000_4000, 0);
        do_write(32'h8000_4000, $urandom, 8'h0F, 0, 0);
        do_read(BASE, 0);
        do_read(BASE + 32'h10, 5);

        // Reset while a read sits in its latency countdown.
        araddr  = pool(3);
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check("rdrst_arready", 32'(arready), 32'd1);
        check("rdrst_rvalid", 32'(rvalid), 32'd0);
        repeat (3) tick();
        check("rdrst_no_stale", 32'(rvalid), 32'd0);
        do_read(BASE + 32'h10, 0);

        // Reset while a write is pending: it must be dropped.
        awaddr  = pool(1);
        wdata   = ~mdl[widx(pool(1))];
        wstrb   = 8'h0F;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("wrrst_bvalid", 32'(bvalid), 32'd0);
        do_read(pool(1), 0);

        // Randomized traffic against the reference memory.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = oor_addr();
            else a = pool($urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 8'($urandom), $urandom_range(0, 6) - 3,
                         $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
